// File: rtl/serdes_tx_pkg.sv
// -----------------------------------------------------------------------------
// serdes_tx_pkg
// Types and constants shared between the TX framer and the 8b/10b encoder side.
//   K28_5          : comma character used for alignment, idle fill and skip slots
//   framer_state_t : framer link state (ALIGN burst or DATA flow)
//   tx_sym_t       : one symbol handed to the encoder, {k, d}
// -----------------------------------------------------------------------------
package serdes_tx_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic {
        ALIGN = 1'b0,
        DATA  = 1'b1
    } framer_state_t;

    typedef struct packed {
        logic       k;
        logic [7:0] d;
    } tx_sym_t;

    // Comma symbol as sent on the link (K flag set).
    function automatic tx_sym_t comma_sym();
        tx_sym_t s;
        s.k = 1'b1;
        s.d = K28_5;
        return s;
    endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// tx_sync_fifo
// Single-clock FIFO with show-ahead head output.
//   clk, rst_n : clock and asynchronous active-low reset
//   push/wdata : write request and data (ignored when full)
//   pop        : read request, consumes rdata (ignored when empty)
//   rdata      : current head entry, valid while !empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module tx_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_en_s;
    logic             pop_en_s;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == {LW{1'b0}});
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; requests are gated by the flags.
    always_comb begin
        push_en_s = push & ~full;
        pop_en_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_en_s, pop_en_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/tx_framer.sv
// -----------------------------------------------------------------------------
// tx_framer
// TX link-layer framer feeding the 8b/10b encoder. One symbol per BitCLK_10.
// Sends an ALIGN_COUNT-long K28.5 burst after reset or Realign, then passes
// buffered user bytes, filling gaps with K28.5 and forcing a K28.5 slot after
// SKIP_INTERVAL-1 consecutive data symbols.
//   BitCLK_10    : word clock
//   Reset        : asynchronous active-low reset
//   TxData_in    : user byte          TxK_in   : user byte is a K character
//   TxValid_in   : user byte valid    TxReady_out : FIFO not full
//   Realign      : one-cycle request to resend the alignment burst
//   TxParallel_8 : symbol to encoder  TxDataK  : symbol is a K character
//   LinkUp       : alignment complete, data flowing
//   Fifo_level   : current FIFO occupancy
// -----------------------------------------------------------------------------
module tx_framer
    import serdes_tx_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int ALIGN_COUNT   = 16,
    parameter int SKIP_INTERVAL = 64
) (
    input  logic                          BitCLK_10,
    input  logic                          Reset,
    input  logic [7:0]                    TxData_in,
    input  logic                          TxK_in,
    input  logic                          TxValid_in,
    output logic                          TxReady_out,
    input  logic                          Realign,
    output logic [7:0]                    TxParallel_8,
    output logic                          TxDataK,
    output logic                          LinkUp,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_level
);

    localparam int AW = $clog2(ALIGN_COUNT) + 1;
    localparam int SW = $clog2(SKIP_INTERVAL) + 1;
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_COUNT - 1);
    localparam logic [SW-1:0] SKIP_LAST  = SW'(SKIP_INTERVAL - 1);

    framer_state_t state_q, state_d, fsm_state_s;
    logic [AW-1:0] align_cnt_q, align_cnt_d, fsm_align_s;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d, fsm_skip_s;
    logic          link_q, link_d, fsm_link_s;
    tx_sym_t       sym_q, sym_d;
    tx_sym_t       wr_sym_s;
    tx_sym_t       head_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;

    assign wr_sym_s.k = TxK_in;
    assign wr_sym_s.d = TxData_in;

    // Input buffer; pushes while full are refused inside the FIFO.
    tx_sync_fifo #(
        .WIDTH ($bits(tx_sym_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (BitCLK_10),
        .rst_n (Reset),
        .push  (TxValid_in),
        .wdata (wr_sym_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (Fifo_level)
    );

    // Ready depends only on the current level, not on a same-cycle pop.
    assign TxReady_out  = ~full_s;
    assign TxParallel_8 = sym_q.d;
    assign TxDataK      = sym_q.k;
    assign LinkUp       = link_q;

    // Symbol selection and state progression; Realign overrides only the
    // control state, the symbol sent this cycle still follows the normal rules.
    always_comb begin
        fsm_state_s = state_q;
        fsm_align_s = align_cnt_q;
        fsm_skip_s  = skip_cnt_q;
        fsm_link_s  = link_q;
        sym_d       = comma_sym();
        pop_s       = 1'b0;
        case (state_q)
            ALIGN: begin
                sym_d = comma_sym();
                if (align_cnt_q == ALIGN_LAST) begin
                    fsm_state_s = DATA;
                    fsm_link_s  = 1'b1;
                    fsm_align_s = {AW{1'b0}};
                    fsm_skip_s  = {SW{1'b0}};
                end else begin
                    fsm_align_s = align_cnt_q + AW'(1);
                end
            end
            DATA: begin
                if (skip_cnt_q == SKIP_LAST) begin
                    // Forced comma keeps the receiver's word alignment.
                    sym_d      = comma_sym();
                    fsm_skip_s = {SW{1'b0}};
                end else if (!empty_s) begin
                    pop_s      = 1'b1;
                    sym_d      = head_s;
                    fsm_skip_s = skip_cnt_q + SW'(1);
                end else begin
                    // Idle fill counts as a comma, so the run restarts.
                    sym_d      = comma_sym();
                    fsm_skip_s = {SW{1'b0}};
                end
            end
            default: begin
                fsm_state_s = ALIGN;
                fsm_link_s  = 1'b0;
                fsm_align_s = {AW{1'b0}};
                fsm_skip_s  = {SW{1'b0}};
                sym_d       = comma_sym();
            end
        endcase
        state_d     = Realign ? ALIGN : fsm_state_s;
        link_d      = Realign ? 1'b0 : fsm_link_s;
        align_cnt_d = Realign ? {AW{1'b0}} : fsm_align_s;
        skip_cnt_d  = Realign ? {SW{1'b0}} : fsm_skip_s;
    end

    // Framer state, counters and registered output symbol.
    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ALIGN;
            align_cnt_q <= {AW{1'b0}};
            skip_cnt_q  <= {SW{1'b0}};
            link_q      <= 1'b0;
            sym_q       <= comma_sym();
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            link_q      <= link_d;
            sym_q       <= sym_d;
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_framer
// Directed bench for tx_framer with a queue-based reference model of the link
// (alignment countdown, FIFO queue, recent-symbol history for comma slots)
// plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_tx_framer;

    localparam int DEPTH = 8;
    localparam int AC    = 16;
    localparam int SI    = 64;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [7:0] BC = 8'hBC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_k = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          realign = 1'b0;
    logic [7:0]    tx_par;
    logic          tx_datak;
    logic          link_up;
    logic [LW-1:0] fifo_level;

    tx_framer #(
        .FIFO_DEPTH    (DEPTH),
        .ALIGN_COUNT   (AC),
        .SKIP_INTERVAL (SI)
    ) dut (
        .BitCLK_10    (clk),
        .Reset        (rst_n),
        .TxData_in    (tx_data),
        .TxK_in       (tx_k),
        .TxValid_in   (tx_valid),
        .TxReady_out  (tx_ready),
        .Realign      (realign),
        .TxParallel_8 (tx_par),
        .TxDataK      (tx_datak),
        .LinkUp       (link_up),
        .Fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [8:0] m_q[$];        // buffered {k,d}
    logic [8:0] src_q[$];      // bytes the source still has to deliver
    bit         src_en = 1'b0;
    bit         m_linked;      // link is in data phase
    int         m_align_left;  // alignment commas still owed
    bit         hist[$];       // last SI-1 data-phase symbols: 1 = data, 0 = comma
    logic [8:0] exp_sym;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A comma is owed when the last SI-1 data-phase symbols were all data.
    function automatic bit comma_owed();
        if (hist.size() < SI - 1) return 1'b0;
        foreach (hist[i]) if (!hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        hist.delete();
        m_linked     = 1'b0;
        m_align_left = AC;
        exp_sym      = {1'b1, BC};
    endtask

    task automatic compare_outputs();
        chk("sym_d", {24'd0, tx_par}, {24'd0, exp_sym[7:0]});
        chk("sym_k", {31'd0, tx_datak}, {31'd0, exp_sym[8]});
        chk("linkup", {31'd0, link_up}, {31'd0, m_linked});
        chk("level", {{(32-LW){1'b0}}, fifo_level}, m_q.size());
        chk("ready", {31'd0, tx_ready}, {31'd0, (m_q.size() != DEPTH)});
    endtask

    // One clock: drive source, advance model, clock, compare.
    task automatic step();
        bit         push;
        logic [8:0] pv;
        tx_valid = src_en && (src_q.size() != 0);
        pv       = tx_valid ? src_q[0] : 9'h000;
        tx_k     = pv[8];
        tx_data  = pv[7:0];
        push     = tx_valid && (m_q.size() != DEPTH);
        if (!m_linked) begin
            exp_sym = {1'b1, BC};
            m_align_left--;
            if (m_align_left == 0) begin
                m_linked = 1'b1;
                hist.delete();
            end
        end else if (comma_owed()) begin
            exp_sym = {1'b1, BC};
            hist.push_back(1'b0);
        end else if (m_q.size() != 0) begin
            exp_sym = m_q.pop_front();
            hist.push_back(1'b1);
        end else begin
            exp_sym = {1'b1, BC};
            hist.push_back(1'b0);
        end
        if (hist.size() > SI - 1) void'(hist.pop_front());
        if (push) m_q.push_back(pv);
        if (realign) begin
            m_linked     = 1'b0;
            m_align_left = AC;
        end
        @(posedge clk);
        #1;
        if (push) void'(src_q.pop_front());
        realign = 1'b0;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        realign  = 1'b0;
        tx_valid = 1'b0;
        src_en   = 1'b0;
        src_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst_sym", {24'd0, tx_par}, 32'h0000_00BC);
        chk("rst_k", {31'd0, tx_datak}, 32'd1);
        chk("rst_link", {31'd0, link_up}, 32'd0);
        chk("rst_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    endtask

    logic [8:0] seq[$];

    initial begin
        model_reset();

        // 1: alignment burst after reset
        do_reset();
        repeat (15) step();
        chk("t1_link_before", {31'd0, link_up}, 32'd0);
        step();
        chk("t1_link_up", {31'd0, link_up}, 32'd1);
        repeat (3) step();
        chk("t1_idle", {23'd0, tx_datak, tx_par}, 32'h0000_01BC);

        // 2: single byte latency
        src_q.push_back({1'b0, 8'h3C});
        src_en = 1'b1;
        step();
        chk("t2_before", {23'd0, tx_datak, tx_par}, 32'h0000_01BC);
        step();
        chk("t2_byte", {23'd0, tx_datak, tx_par}, 32'h0000_003C);
        step();
        chk("t2_after", {23'd0, tx_datak, tx_par}, 32'h0000_01BC);

        // 3: fill FIFO during ALIGN, drain at LinkUp
        do_reset();
        for (int i = 0; i < 10; i++) src_q.push_back({1'b0, 8'hA0 + 8'(i)});
        src_en = 1'b1;
        repeat (8) step();
        chk("t3_full_level", {{(32-LW){1'b0}}, fifo_level}, 32'd8);
        chk("t3_not_ready", {31'd0, tx_ready}, 32'd0);
        repeat (8) step();
        chk("t3_link", {31'd0, link_up}, 32'd1);
        step();
        chk("t3_first", {23'd0, tx_datak, tx_par}, 32'h0000_00A0);
        chk("t3_lvl7", {{(32-LW){1'b0}}, fifo_level}, 32'd7);
        chk("t3_ready_back", {31'd0, tx_ready}, 32'd1);
        step();
        chk("t3_second", {23'd0, tx_datak, tx_par}, 32'h0000_00A1);
        repeat (12) step();

        // 4: continuous stream, forced comma every 64th symbol
        for (int i = 0; i < 230; i++) src_q.push_back({1'b0, 8'(i)});
        src_en = 1'b1;
        for (int i = 0; i < 220; i++) begin
            step();
            seq.push_back({tx_datak, tx_par});
        end
        begin
            int first_data = -1;
            int last_comma = -1;
            int ncommas = 0;
            int expv = 0;
            foreach (seq[i]) begin
                if (!seq[i][8]) begin
                    if (first_data < 0) first_data = i;
                    chk("t4_order", {24'd0, seq[i][7:0]}, expv & 255);
                    expv++;
                end else if (first_data >= 0) begin
                    if (last_comma < 0) chk("t4_first_gap", i - first_data, 32'd63);
                    else chk("t4_gap", i - last_comma, 32'd64);
                    last_comma = i;
                    ncommas++;
                end
            end
            chk("t4_commas", ncommas, 32'd3);
        end
        src_en = 1'b0;
        src_q.delete();
        for (int i = 0; i < 20 && m_q.size() != 0; i++) step();
        chk("t4_drained", {{(32-LW){1'b0}}, fifo_level}, 32'd0);

        // 5: Realign with 3 bytes buffered
        src_q.push_back({1'b0, 8'h51});
        src_q.push_back({1'b0, 8'h52});
        src_q.push_back({1'b1, 8'h53});
        src_en  = 1'b1;
        realign = 1'b1;
        step();
        chk("t5_link_drop", {31'd0, link_up}, 32'd0);
        repeat (15) step();
        chk("t5_link_still_down", {31'd0, link_up}, 32'd0);
        chk("t5_level3", {{(32-LW){1'b0}}, fifo_level}, 32'd3);
        step();
        chk("t5_link_up", {31'd0, link_up}, 32'd1);
        step();
        chk("t5_b0", {23'd0, tx_datak, tx_par}, 32'h0000_0051);
        step();
        chk("t5_b1", {23'd0, tx_datak, tx_par}, 32'h0000_0052);
        step();
        chk("t5_b2", {23'd0, tx_datak, tx_par}, 32'h0000_0153);
        step();

        // 6: reset mid-stream with FIFO half full
        for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 8'h70 + 8'(i)});
        realign = 1'b1;
        repeat (4) step();
        chk("t6_half", {{(32-LW){1'b0}}, fifo_level}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sym", {23'd0, tx_datak, tx_par}, 32'h0000_01BC);
        chk("t6_rst_link", {31'd0, link_up}, 32'd0);
        chk("t6_rst_level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        src_en = 1'b0;
        src_q.delete();
        tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (16) step();
        chk("t6_link", {31'd0, link_up}, 32'd1);
        repeat (10) step();
        chk("t6_no_stale", {23'd0, tx_datak, tx_par}, 32'h0000_01BC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
